branch_stack: RTL and testbench

- In-flight branch tracker between dispatch and execute; feeds the branch predictor its resolution inputs.
- Allocates one entry per dispatched branch and stores that branch's BRANCH_PREDICTOR_PACKET.
- On resolution from execute, returns the stored packet to the predictor one cycle later, squashes younger entries on mispredict, and frees resolved entries in program order.

---
 rtl/branch_stack.sv | 213 +++++++++++++++++++++
 tb/tb_branch_stack.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_stack.sv
// branch_stack: in-flight branch tracker between dispatch and execute.
// Optional perf counters: define BS_PERF_CNT_EN.
`ifndef N
`define N 2
`endif

package branch_stack_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred_taken;
  } BRANCH_PREDICTOR_PACKET;
endpackage

module branch_stack
  import branch_stack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [`N-1:0]          dispatch_valid,
  input  BRANCH_PREDICTOR_PACKET [`N-1:0]
                                 dispatch_bp_packets,
  output logic                   dispatch_stall,
  output logic [`N-1:0][TAG_W-1:0]
                                 dispatch_tags,
  output logic [TAG_W:0]         free_count,
  input  logic                   ex_resolve_valid,
  input  logic [TAG_W-1:0]       ex_resolve_tag,
  input  logic                   ex_actual_taken,
  input  logic                   ex_mispred,
  output BRANCH_PREDICTOR_PACKET bs_bp_packet,
  output logic                   resolving_valid_branch,
  output logic                   actual_taken,
  output logic                   mispred,
  output logic [DEPTH-1:0]       squash_mask
`ifdef BS_PERF_CNT_EN
  ,
  output logic [31:0]            perf_resolved,
  output logic [31:0]            perf_mispred
`endif
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] ONE     = (TAG_W+1)'(1);

  logic [TAG_W:0]   head_q, head_d;
  logic [TAG_W:0]   tail_q, tail_d;
  logic [TAG_W:0]   free_q, free_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] res_q, res_d;
  logic [DEPTH-1:0] sq_q;
  logic             rvb_q, rvb_d;
  logic             tkn_q, tkn_d;
  logic             mis_q, mis_d;

  BRANCH_PREDICTOR_PACKET pkt_q [DEPTH];
  BRANCH_PREDICTOR_PACKET opkt_q, opkt_d;

  logic [TAG_W-1:0] head_lo;
  logic [TAG_W-1:0] rdist;
  logic [TAG_W-1:0] ridx;
  logic [TAG_W:0]   disp_cnt;
  logic [TAG_W:0]   ret_cnt;
  logic             res_ok;
  logic             mis_ok;
  logic             alloc_en;
  logic             run;
  logic [DEPTH-1:0] sq_mask;
  logic [DEPTH-1:0] ret_mask;
  logic [DEPTH-1:0] alloc_mask;
  logic [DEPTH-1:0] res_hot;

  assign head_lo = head_q[TAG_W-1:0];
  assign rdist   = ex_resolve_tag - head_lo;

  // Compacted tags: each valid slot takes the next free index.
  always_comb begin
    disp_cnt = '0;
    for (int i = 0; i < `N; i++) begin
      dispatch_tags[i] = tail_q[TAG_W-1:0]
                       + disp_cnt[TAG_W-1:0];
      disp_cnt = disp_cnt
               + {{TAG_W{1'b0}}, dispatch_valid[i]};
    end
  end

  assign dispatch_stall = disp_cnt > free_q;

  assign res_ok = ex_resolve_valid
               && vld_q[ex_resolve_tag]
               && !res_q[ex_resolve_tag];
  assign mis_ok   = res_ok && ex_mispred;
  assign alloc_en = !dispatch_stall && !mis_ok;
  assign res_hot  = res_ok
                  ? (DEPTH'(1) << ex_resolve_tag)
                  : '0;

  // Younger than the resolving branch = larger distance from head.
  always_comb begin
    sq_mask = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (mis_ok && vld_q[e]
          && ((TAG_W'(e) - head_lo) > rdist))
        sq_mask[e] = 1'b1;
    end
  end

  always_comb begin
    ret_cnt  = '0;
    ret_mask = '0;
    run      = 1'b1;
    ridx     = '0;
    for (int k = 0; k < `N; k++) begin
      ridx = head_lo + TAG_W'(k);
      if (run && vld_q[ridx] && res_q[ridx]) begin
        ret_mask[ridx] = 1'b1;
        ret_cnt        = ret_cnt + ONE;
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    alloc_mask = '0;
    for (int i = 0; i < `N; i++) begin
      if (alloc_en && dispatch_valid[i])
        alloc_mask[dispatch_tags[i]] = 1'b1;
    end
  end

  always_comb begin
    tail_d = tail_q;
    if (mis_ok)
      tail_d = head_q + {1'b0, rdist} + ONE;
    else if (alloc_en)
      tail_d = tail_q + disp_cnt;
    head_d = head_q + ret_cnt;
    free_d = DEPTH_C - (tail_d - head_d);
    vld_d  = (vld_q & ~ret_mask & ~sq_mask)
           | alloc_mask;
    res_d  = (res_q & ~ret_mask & ~sq_mask
              & ~alloc_mask) | res_hot;
    rvb_d  = res_ok;
    tkn_d  = res_ok && ex_actual_taken;
    mis_d  = mis_ok;
    opkt_d = res_ok ? pkt_q[ex_resolve_tag] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      free_q <= DEPTH_C;
      vld_q  <= '0;
      res_q  <= '0;
      sq_q   <= '0;
      rvb_q  <= 1'b0;
      tkn_q  <= 1'b0;
      mis_q  <= 1'b0;
      opkt_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      free_q <= free_d;
      vld_q  <= vld_d;
      res_q  <= res_d;
      sq_q   <= sq_mask;
      rvb_q  <= rvb_d;
      tkn_q  <= tkn_d;
      mis_q  <= mis_d;
      opkt_q <= opkt_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < `N; i++) begin
      if (alloc_en && dispatch_valid[i])
        pkt_q[dispatch_tags[i]] <= dispatch_bp_packets[i];
    end
  end

  assign free_count             = free_q;
  assign bs_bp_packet           = opkt_q;
  assign resolving_valid_branch = rvb_q;
  assign actual_taken           = tkn_q;
  assign mispred                = mis_q;
  assign squash_mask            = sq_q;

`ifdef BS_PERF_CNT_EN
  logic [31:0] perf_res_q;
  logic [31:0] perf_mis_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_res_q <= '0;
      perf_mis_q <= '0;
    end else begin
      if (res_ok && (perf_res_q != '1))
        perf_res_q <= perf_res_q + 32'd1;
      if (mis_ok && (perf_mis_q != '1))
        perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign perf_resolved = perf_res_q;
  assign perf_mispred  = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_stack.sv
// tb_branch_stack: directed bench for branch_stack (DEPTH=8, N=2).
// Resolve responses go through a scoreboard queue and a monitor.
`ifndef N
`define N 2
`endif

module tb_branch_stack;
  import branch_stack_pkg::*;

  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [`N-1:0]          dispatch_valid;
  BRANCH_PREDICTOR_PACKET [`N-1:0] disp_pkts;
  logic                   dispatch_stall;
  logic [`N-1:0][TAG_W-1:0] dispatch_tags;
  logic [TAG_W:0]         free_count;
  logic                   ex_resolve_valid;
  logic [TAG_W-1:0]       ex_resolve_tag;
  logic                   ex_actual_taken;
  logic                   ex_mispred;
  BRANCH_PREDICTOR_PACKET bs_bp_packet;
  logic                   resolving_valid_branch;
  logic                   actual_taken;
  logic                   mispred;
  logic [DEPTH-1:0]       squash_mask;
`ifdef BS_PERF_CNT_EN
  logic [31:0]            perf_resolved;
  logic [31:0]            perf_mispred;
`endif

  always #5 clock = ~clock;

  branch_stack #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .dispatch_valid         (dispatch_valid),
    .dispatch_bp_packets    (disp_pkts),
    .dispatch_stall         (dispatch_stall),
    .dispatch_tags          (dispatch_tags),
    .free_count             (free_count),
    .ex_resolve_valid       (ex_resolve_valid),
    .ex_resolve_tag         (ex_resolve_tag),
    .ex_actual_taken        (ex_actual_taken),
    .ex_mispred             (ex_mispred),
    .bs_bp_packet           (bs_bp_packet),
    .resolving_valid_branch (resolving_valid_branch),
    .actual_taken           (actual_taken),
    .mispred                (mispred),
    .squash_mask            (squash_mask)
`ifdef BS_PERF_CNT_EN
    ,
    .perf_resolved          (perf_resolved),
    .perf_mispred           (perf_mispred)
`endif
  );

  typedef struct {
    logic                   rvb;
    logic                   tkn;
    logic                   mis;
    BRANCH_PREDICTOR_PACKET pkt;
    logic [DEPTH-1:0]       sq;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic issued_q = 1'b0;

  task automatic chk(input string name,
                     input logic [95:0] act,
                     input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  name, act, exp);
  endtask

  function automatic BRANCH_PREDICTOR_PACKET mkpkt(input int k);
    BRANCH_PREDICTOR_PACKET p;
    p.pc         = 32'h1000 + 32'(k) * 32'd4;
    p.target     = 32'h8000_0000 | 32'(k);
    p.pred_taken = k[0];
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dispatch_valid   = '0;
    ex_resolve_valid = 1'b0;
    ex_resolve_tag   = '0;
    ex_actual_taken  = 1'b0;
    ex_mispred       = 1'b0;
  endtask

  task automatic disp(input logic [`N-1:0] v,
                      input int k0, input int k1);
    dispatch_valid = v;
    disp_pkts[0]   = mkpkt(k0);
    disp_pkts[1]   = mkpkt(k1);
  endtask

  // ok = resolve should be accepted; k = packet id stored at tag
  task automatic resolve(input int tag, input logic tk,
                         input logic mp, input logic ok,
                         input int k,
                         input logic [DEPTH-1:0] sq);
    exp_t e;
    ex_resolve_valid = 1'b1;
    ex_resolve_tag   = TAG_W'(tag);
    ex_actual_taken  = tk;
    ex_mispred       = mp;
    e.rvb = ok;
    e.tkn = ok & tk;
    e.mis = ok & mp;
    e.pkt = ok ? mkpkt(k) : '0;
    e.sq  = sq;
    sb.push_back(e);
  endtask

  always @(posedge clock) issued_q <= ex_resolve_valid;

  always @(negedge clock) begin
    if (issued_q) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_empty: response seen, none expected");
      end else begin
        me = sb.pop_front();
        chk("mon_rvb", 96'(resolving_valid_branch), 96'(me.rvb));
        chk("mon_taken", 96'(actual_taken), 96'(me.tkn));
        chk("mon_mispred", 96'(mispred), 96'(me.mis));
        chk("mon_pkt", 96'(bs_bp_packet), 96'(me.pkt));
        chk("mon_squash", 96'(squash_mask), 96'(me.sq));
      end
    end else if (resolving_valid_branch || mispred
                 || (squash_mask != '0)) begin
      n_checks++;
      $display("FAIL spurious: rvb=%0b mispred=%0b sq=%0h, expected 0",
               resolving_valid_branch, mispred, squash_mask);
    end
  end

  initial begin
    reset     = 1'b1;
    disp_pkts = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_free", 96'(free_count), 96'(8));
    chk("rst_rvb", 96'(resolving_valid_branch), 96'(0));
    chk("rst_taken", 96'(actual_taken), 96'(0));
    chk("rst_mispred", 96'(mispred), 96'(0));
    chk("rst_squash", 96'(squash_mask), 96'(0));
    chk("rst_pkt", 96'(bs_bp_packet), 96'(0));

    disp(2'b11, 0, 1); #1;
    chk("alloc_tag0", 96'(dispatch_tags[0]), 96'(0));
    chk("alloc_tag1", 96'(dispatch_tags[1]), 96'(1));
    chk("alloc_stall", 96'(dispatch_stall), 96'(0));
    tick();
    idle();
    chk("alloc_free", 96'(free_count), 96'(6));

    disp(2'b01, 2, 0); #1;
    chk("fill_tag2", 96'(dispatch_tags[0]), 96'(2));
    tick();
    disp(2'b11, 3, 4); #1;
    chk("fill_tag3", 96'(dispatch_tags[0]), 96'(3));
    chk("fill_tag4", 96'(dispatch_tags[1]), 96'(4));
    tick();
    disp(2'b11, 5, 6); #1;
    tick();
    disp(2'b01, 7, 0); #1;
    chk("fill_tag7", 96'(dispatch_tags[0]), 96'(7));
    tick();
    idle();
    chk("full_free", 96'(free_count), 96'(0));

    disp(2'b01, 99, 0); #1;
    chk("full_stall", 96'(dispatch_stall), 96'(1));
    tick();
    chk("full_tail", 96'(dispatch_tags[0]), 96'(0));
    chk("full_free2", 96'(free_count), 96'(0));
    idle();

    resolve(1, 1'b1, 1'b0, 1'b1, 1, '0);
    tick();
    idle();
    tick();
    chk("no_early_retire", 96'(free_count), 96'(0));
    resolve(1, 1'b1, 1'b0, 1'b0, 0, '0);
    tick();
    idle();
    resolve(0, 1'b0, 1'b0, 1'b1, 0, '0);
    tick();
    idle();
    tick();
    chk("retire_pair", 96'(free_count), 96'(2));

    reset = 1'b1;
    resolve(3, 1'b0, 1'b1, 1'b0, 0, '0);
    tick();
    reset = 1'b0;
    idle();
    chk("midrst_free", 96'(free_count), 96'(8));

    disp(2'b11, 10, 11); #1;
    chk("rst_tag0", 96'(dispatch_tags[0]), 96'(0));
    chk("rst_tag1", 96'(dispatch_tags[1]), 96'(1));
    tick();
    disp(2'b11, 12, 13);
    tick();
    disp(2'b11, 14, 15);
    tick();
    idle();
    chk("six_free", 96'(free_count), 96'(2));

    resolve(2, 1'b0, 1'b1, 1'b1, 12, 8'b0011_1000);
    disp(2'b11, 16, 17);
    tick();
    idle();
    chk("mp_free", 96'(free_count), 96'(5));
    disp(2'b01, 18, 0); #1;
    chk("mp_tail", 96'(dispatch_tags[0]), 96'(3));
    tick();
    idle();
    chk("mp_discard", 96'(free_count), 96'(4));

    resolve(4, 1'b0, 1'b0, 1'b0, 0, '0);
    tick();
    idle();
    resolve(0, 1'b0, 1'b0, 1'b1, 10, '0);
    tick();
    resolve(1, 1'b1, 1'b0, 1'b1, 11, '0);
    tick();
    resolve(3, 1'b1, 1'b0, 1'b1, 18, '0);
    tick();
    idle();
    tick();
    tick();
    chk("drain_free", 96'(free_count), 96'(8));

    disp(2'b11, 20, 21); #1;
    chk("wrap_tag4", 96'(dispatch_tags[0]), 96'(4));
    tick();
    disp(2'b11, 22, 23);
    resolve(4, 1'b0, 1'b0, 1'b1, 20, '0); #1;
    chk("wrap_tag6", 96'(dispatch_tags[0]), 96'(6));
    tick();
    disp(2'b11, 24, 25);
    resolve(5, 1'b1, 1'b0, 1'b1, 21, '0); #1;
    chk("wrap_tag0", 96'(dispatch_tags[0]), 96'(0));
    chk("wrap_tag1", 96'(dispatch_tags[1]), 96'(1));
    tick();
    idle();
    tick();
    chk("wrap_free", 96'(free_count), 96'(4));

    resolve(7, 1'b1, 1'b1, 1'b1, 23, 8'b0000_0011);
    tick();
    idle();
    chk("wrap_mp_free", 96'(free_count), 96'(6));
    disp(2'b01, 26, 0); #1;
    chk("wrap_mp_tail", 96'(dispatch_tags[0]), 96'(0));
    tick();
    idle();
    resolve(1, 1'b0, 1'b0, 1'b0, 0, '0);
    tick();
    idle();
    tick();
    tick();

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL sb_leftover: %0d responses never seen",
               sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
